// File: rtl/alu_issue_stage.sv
// Decode, register-read and writeback stage in front of the 64-bit integer ALU.
// Handles RV64I OP / OP-IMM (ADD/SUB, XOR, OR, AND) with EX-to-decode bypass.
module alu_issue_stage #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic            stall,
   output logic [2:0]      alu_func,
   output logic            alu_sign,
   output logic [XLEN-1:0] alu_op_a,
   output logic [XLEN-1:0] alu_op_b,
   input  logic [XLEN-1:0] alu_res,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;

   // Reset and handshake
   logic rst_n_q;
   logic xfer;

   always_ff @(posedge clk) begin
      rst_n_q <= rst_n;
   end

   assign in_ready = rst_n_q & ~stall;
   assign xfer     = in_valid & in_ready;

   // Decode
   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            is_op;
   logic            is_op_imm;
   logic            func3_ok;
   logic            legal;
   logic [XLEN-1:0] imm;

   assign opcode    = in_instr[6:0];
   assign rd        = in_instr[11:7];
   assign func3     = in_instr[14:12];
   assign rs1       = in_instr[19:15];
   assign rs2       = in_instr[24:20];
   assign is_op     = (opcode == OpcOp);
   assign is_op_imm = (opcode == OpcOpImm);
   assign imm       = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

   always_comb begin
      func3_ok = 1'b0;
      unique case (func3)
         3'b000, 3'b100, 3'b110, 3'b111: func3_ok = 1'b1;
         default:                        func3_ok = 1'b0;
      endcase
   end

   assign legal = (is_op | is_op_imm) & func3_ok;

   // EX pipeline register
   logic            ex_valid_q;
   logic [2:0]      ex_func_q;
   logic            ex_sign_q;
   logic [XLEN-1:0] ex_op_a_q;
   logic [XLEN-1:0] ex_op_b_q;
   logic [4:0]      ex_rd_q;

   // Register file and operand read
   logic [XLEN-1:0] rf_q [NREGS];
   logic            byp_ok;
   logic            wb_fire;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] op_b_sel;
   logic            sign_sel;

   // Bypass only when the EX instruction is actually retiring this cycle.
   assign byp_ok  = ex_valid_q & ~stall & (ex_rd_q != 5'd0);
   assign wb_fire = byp_ok;

   always_comb begin
      rs1_val = '0;
      if (rs1 != 5'd0) begin
         if (byp_ok && (ex_rd_q == rs1)) begin
            rs1_val = alu_res;
         end else begin
            rs1_val = rf_q[rs1];
         end
      end
   end

   always_comb begin
      rs2_val = '0;
      if (rs2 != 5'd0) begin
         if (byp_ok && (ex_rd_q == rs2)) begin
            rs2_val = alu_res;
         end else begin
            rs2_val = rf_q[rs2];
         end
      end
   end

   always_comb begin
      op_b_sel = imm;
      sign_sel = 1'b0;
      if (is_op) begin
         op_b_sel = rs2_val;
         sign_sel = in_instr[30];
      end
   end

   // Illegal instructions leave the ALU inputs untouched and only drop the valid bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_func_q  <= 3'b000;
         ex_sign_q  <= 1'b0;
         ex_op_a_q  <= '0;
         ex_op_b_q  <= '0;
         ex_rd_q    <= 5'd0;
      end else if (xfer) begin
         ex_valid_q <= legal;
         if (legal) begin
            ex_func_q <= func3;
            ex_sign_q <= sign_sel;
            ex_op_a_q <= rs1_val;
            ex_op_b_q <= op_b_sel;
            ex_rd_q   <= rd;
         end
      end else if (!stall) begin
         ex_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_fire) begin
         rf_q[ex_rd_q] <= alu_res;
      end
   end

   // Writeback report and illegal pulse
   logic            wb_valid_q;
   logic [4:0]      wb_rd_q;
   logic [XLEN-1:0] wb_data_q;
   logic            illegal_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= '0;
         illegal_q  <= 1'b0;
      end else begin
         wb_valid_q <= wb_fire;
         illegal_q  <= xfer & ~legal;
         if (wb_fire) begin
            wb_rd_q   <= ex_rd_q;
            wb_data_q <= alu_res;
         end
      end
   end

   assign alu_func = ex_func_q;
   assign alu_sign = ex_sign_q;
   assign alu_op_a = ex_op_a_q;
   assign alu_op_b = ex_op_b_q;
   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign illegal  = illegal_q;
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table for back-to-back issue,
// a writeback scoreboard, and hand sequences for stall and mid-flight reset.
module tb_alu_issue_stage;

   localparam int unsigned XLEN = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            stall;
   logic [2:0]      alu_func;
   logic            alu_sign;
   logic [XLEN-1:0] alu_op_a;
   logic [XLEN-1:0] alu_op_b;
   logic [XLEN-1:0] alu_res;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            illegal;
   logic [4:0]      dbg_addr;
   logic [XLEN-1:0] dbg_data;

   alu_issue_stage #(.XLEN(XLEN), .NREGS(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .stall    (stall),
      .alu_func (alu_func),
      .alu_sign (alu_sign),
      .alu_op_a (alu_op_a),
      .alu_op_b (alu_op_b),
      .alu_res  (alu_res),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .illegal  (illegal),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   // Downstream ALU model
   always_comb begin
      alu_res = '0;
      case (alu_func)
         3'b000:  alu_res = alu_sign ? (alu_op_a - alu_op_b) : (alu_op_a + alu_op_b);
         3'b100:  alu_res = alu_op_a ^ alu_op_b;
         3'b110:  alu_res = alu_op_a | alu_op_b;
         3'b111:  alu_res = alu_op_a & alu_op_b;
         default: alu_res = '0;
      endcase
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      int          cyc;
   } sb_t;

   sb_t sb[$];

   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h want no writeback", wb_rd, wb_data);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("wb_rd", 64'(wb_rd), 64'(e.rd));
            chk("wb_data", wb_data, e.data);
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic        ill;
      logic [4:0]  rd;
      logic [63:0] res;
      logic [2:0]  func;
      logic        sign;
      logic [63:0] a;
      logic [63:0] b;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] instr, input logic ill, input logic [4:0] rd,
                               input logic [63:0] res, input logic [2:0] func,
                               input logic sign, input logic [63:0] a, input logic [63:0] b);
      vec_t v;
      v.instr = instr; v.ill = ill; v.rd = rd; v.res = res;
      v.func = func; v.sign = sign; v.a = a; v.b = b;
      return v;
   endfunction

   localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

   vec_t vec[12];

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] val;
   } dbg_t;

   dbg_t dbg_exp[13];

   initial begin
      int cn;

      // Bubbles (ill=1) expect the ALU inputs of the last legal instruction (and x7,x5).
      vec[0]  = mk(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 1'b0, 5'd1, 64'd5, 3'b000, 1'b0, 64'd0, 64'd5);
      vec[1]  = mk(enc_i(12'd7, 5'd0, 3'b000, 5'd2), 1'b0, 5'd2, 64'd7, 3'b000, 1'b0, 64'd0, 64'd7);
      vec[2]  = mk(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 5'd3, 64'd12, 3'b000, 1'b0,
                   64'd5, 64'd7);
      vec[3]  = mk(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1), 1'b0, 5'd1, Ones, 3'b000, 1'b0, 64'd0, Ones);
      vec[4]  = mk(enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd4), 1'b0, 5'd4, 64'd1, 3'b000, 1'b1,
                   64'd0, Ones);
      vec[5]  = mk(enc_i(12'h0F0, 5'd0, 3'b000, 5'd5), 1'b0, 5'd5, 64'hF0, 3'b000, 1'b0,
                   64'd0, 64'hF0);
      vec[6]  = mk(enc_i(12'h0FF, 5'd5, 3'b100, 5'd6), 1'b0, 5'd6, 64'h0F, 3'b100, 1'b0,
                   64'hF0, 64'hFF);
      vec[7]  = mk(enc_i(12'h100, 5'd6, 3'b110, 5'd7), 1'b0, 5'd7, 64'h10F, 3'b110, 1'b0,
                   64'h0F, 64'h100);
      vec[8]  = mk(enc_r(7'h00, 5'd5, 5'd7, 3'b111, 5'd8), 1'b0, 5'd8, 64'h0, 3'b111, 1'b0,
                   64'h10F, 64'hF0);
      vec[9]  = mk(enc_i(12'd1, 5'd1, 3'b001, 5'd9), 1'b1, 5'd9, 64'h0, 3'b111, 1'b0,
                   64'h10F, 64'hF0);
      vec[10] = mk({12'h0, 5'd1, 3'b011, 5'd12, 7'b0000011}, 1'b1, 5'd12, 64'h0, 3'b111, 1'b0,
                   64'h10F, 64'hF0);
      vec[11] = mk(enc_i(12'd9, 5'd0, 3'b000, 5'd0), 1'b0, 5'd0, 64'd9, 3'b000, 1'b0,
                   64'd0, 64'd9);

      dbg_exp[0]  = '{5'd0, 64'd0};
      dbg_exp[1]  = '{5'd1, Ones};
      dbg_exp[2]  = '{5'd2, 64'd7};
      dbg_exp[3]  = '{5'd3, 64'd12};
      dbg_exp[4]  = '{5'd4, 64'd1};
      dbg_exp[5]  = '{5'd5, 64'hF0};
      dbg_exp[6]  = '{5'd6, 64'h0F};
      dbg_exp[7]  = '{5'd7, 64'h10F};
      dbg_exp[8]  = '{5'd8, 64'h0};
      dbg_exp[9]  = '{5'd9, 64'h0};
      dbg_exp[10] = '{5'd12, 64'h0};
      dbg_exp[11] = '{5'd10, 64'd3};
      dbg_exp[12] = '{5'd11, 64'd0};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      stall    = 1'b0;
      dbg_addr = 5'd0;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_alu_a", alu_op_a, 64'd0);
      chk("rst_alu_b", alu_op_b, 64'd0);
      chk("rst_alu_fs", {60'd0, alu_func, alu_sign}, 64'd0);
      rst_n = 1'b1;
      chk("rst_ready_lag", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      // Back-to-back issue from the vector table
      for (int i = 0; i < 12; i++) begin
         in_instr = vec[i].instr;
         in_valid = 1'b1;
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
         @(negedge clk);
         cn = cyc;
         if (!vec[i].ill && vec[i].rd != 5'd0) sb.push_back('{vec[i].rd, vec[i].res, cn + 1});
         chk($sformatf("v%0d_illegal", i), 64'(illegal), 64'(vec[i].ill));
         chk($sformatf("v%0d_func", i), 64'(alu_func), 64'(vec[i].func));
         chk($sformatf("v%0d_sign", i), 64'(alu_sign), 64'(vec[i].sign));
         chk($sformatf("v%0d_op_a", i), alu_op_a, vec[i].a);
         chk($sformatf("v%0d_op_b", i), alu_op_b, vec[i].b);
      end

      // Stall for three cycles right after accepting addi x10,x0,3
      in_instr = enc_i(12'd3, 5'd0, 3'b000, 5'd10);
      chk("st_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      cn = cyc;
      in_valid = 1'b0;
      stall    = 1'b1;
      sb.push_back('{5'd10, 64'd3, cn + 4});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("st%0d_in_ready", k), 64'(in_ready), 64'd0);
         chk($sformatf("st%0d_op_a", k), alu_op_a, 64'd0);
         chk($sformatf("st%0d_op_b", k), alu_op_b, 64'd3);
         chk($sformatf("st%0d_fs", k), {60'd0, alu_func, alu_sign}, 64'd0);
      end
      stall = 1'b0;
      repeat (3) @(negedge clk);

      for (int k = 0; k < 12; k++) begin
         dbg_addr = dbg_exp[k].addr;
         #1;
         chk($sformatf("dbg_x%0d", dbg_exp[k].addr), dbg_data, dbg_exp[k].val);
      end

      // Reset while addi x11,x0,1 sits in EX: it must not retire
      @(negedge clk);
      in_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd11);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("mrst_in_ready", 64'(in_ready), 64'd0);
      chk("mrst_wb_valid", 64'(wb_valid), 64'd0);
      chk("mrst_alu_b", alu_op_b, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_ready_lag", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("mrst_ready_up", 64'(in_ready), 64'd1);
      for (int r = 0; r < 32; r++) begin
         dbg_addr = 5'(r);
         #1;
         chk($sformatf("mrst_x%0d", r), dbg_data, 64'd0);
      end
      repeat (3) @(negedge clk);

      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL wb_missing: got %0d pending writebacks want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
